// File: rtl/regfile_dump_reader.sv
// Debug reader that walks a register-file read port from FIRST_REG to LAST_REG and
// streams each word with its index over valid/ready, keeping a running checksum.
module regfile_dump_reader #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;

  // Single sequential process: state and every output are registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rd_addr  <= FIRST_IDX;
            checksum <= '0;
            busy     <= 1'b1;
            state    <= READ;
          end
        end

        READ: begin
          if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            out_data  <= rd_data;
            out_index <= rd_addr;
            out_last  <= (rd_addr == LAST_IDX);
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end

        SEND: begin
          // abort outranks a same-cycle handshake, so that beat is never summed
          if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (out_ready) begin
            checksum  <= checksum + out_data;
            out_valid <= 1'b0;
            if (out_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rd_addr <= rd_addr + ADDR_W'(1);
              state   <= READ;
            end
          end
        end

        DONE: begin
          out_last <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
